// File: rtl/idli_sqi_sram_m_if.sv
// SQI bus between the controller (master) and the SRAM responder (slave).
// Nibbles travel MSB-first, one per rising SCK, while i_sram_cs is low.
interface idli_sqi_sram_m_if;
  logic       i_sram_cs;
  logic [3:0] i_sram_data;
  logic [3:0] o_sram_data;
  logic       o_sram_oe;

  // Handshake: there is no valid/ready pair. The controller owns the bus while
  // o_sram_oe is low, and a nibble counts as transferred on every rising SCK
  // with i_sram_cs low. While o_sram_oe is high the responder owns the data lines.
  modport master (
    output i_sram_cs,
    output i_sram_data,
    input  o_sram_data,
    input  o_sram_oe
  );

  modport slave (
    input  i_sram_cs,
    input  i_sram_data,
    output o_sram_data,
    output o_sram_oe
  );
endinterface

// File: rtl/idli_sqi_sram_m.sv
// SQI serial SRAM responder: decodes READ/WRITE transactions from the
// controller and serves an internal 2^ADDR_W byte array with auto-increment.
module idli_sqi_sram_m #(
  parameter int ADDR_W = 8
) (
  input  logic                 i_sram_sck,
  input  logic                 i_ctrl_rst_n,
  idli_sqi_sram_m_if.slave     sqi,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    CMD0   = 3'd0,
    CMD1   = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [3:0]          cmd_hi;
  logic                is_read;
  logic [ADDR_W-1:0]   addr;
  logic [3:0]          hold;
  logic [3:0]          rdata;
  logic [7:0]          mem [2**ADDR_W];

  logic                arst_n;
  logic [7:0]          cmd_full;
  logic [ADDR_W+3:0]   addr_shift;
  logic [7:0]          mem_rd;

  // CS high acts exactly like reset for everything except the array.
  assign arst_n     = i_ctrl_rst_n & ~sqi.i_sram_cs;
  assign cmd_full   = {cmd_hi, sqi.i_sram_data};
  assign addr_shift = {addr, sqi.i_sram_data};
  assign mem_rd     = mem[addr];

  assign sqi.o_sram_data = rdata;
  assign sqi.o_sram_oe   = (state == RDATA) & ~sqi.i_sram_cs;
  assign dbg_state       = state;

  always_ff @(posedge i_sram_sck or negedge arst_n) begin
    if (!arst_n) begin
      state   <= CMD0;
      cnt     <= 2'd0;
      cmd_hi  <= 4'd0;
      is_read <= 1'b0;
      addr    <= '0;
      hold    <= 4'd0;
      rdata   <= 4'd0;
    end else begin
      case (state)
        CMD0: begin
          cmd_hi <= sqi.i_sram_data;
          state  <= CMD1;
        end
        CMD1: begin
          cnt     <= 2'd0;
          is_read <= (cmd_full == 8'h03);
          if (cmd_full == 8'h03 || cmd_full == 8'h02) state <= ADDR;
          else                                         state <= IGNORE;
        end
        ADDR: begin
          // Shifting through an ADDR_W register keeps only the low address bits.
          addr <= addr_shift[ADDR_W-1:0];
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            cnt   <= 2'd0;
            state <= is_read ? DUMMY : WDATA;
          end
        end
        DUMMY: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd1) begin
            rdata <= mem_rd[7:4];
            cnt   <= 2'd1;
            state <= RDATA;
          end
        end
        RDATA: begin
          if (cnt == 2'd1) begin
            rdata <= mem_rd[3:0];
            addr  <= addr + ADDR_W'(1);
            cnt   <= 2'd0;
          end else begin
            rdata <= mem_rd[7:4];
            cnt   <= 2'd1;
          end
        end
        WDATA: begin
          if (cnt == 2'd0) begin
            hold <= sqi.i_sram_data;
            cnt  <= 2'd1;
          end else begin
            addr <= addr + ADDR_W'(1);
            cnt  <= 2'd0;
          end
        end
        default: state <= IGNORE;
      endcase
    end
  end

  // The array has no reset so its contents survive CS and reset.
  always_ff @(posedge i_sram_sck) begin
    if (arst_n && state == WDATA && cnt == 2'd1)
      mem[addr] <= {hold, sqi.i_sram_data};
  end

endmodule

// File: doc/idli_sqi_sram_m.md
# idli_sqi_sram_m

Synthesizable SQI (quad-SPI) serial SRAM responder: the memory-side end of the SQI bus that the core's controller drives. It decodes the controller's command, address, dummy and data nibbles, then returns read data or stores write data in an internal byte array with sequential auto-increment. It is used as the on-chip/FPGA memory model for system bring-up and as the reference responder in controller verification.

## Interface

- ADDR_W, 8, internal byte-array address width (4..16); array holds 2^ADDR_W bytes.

- i_sram_sck  in  1  SQI clock; all sampling and output updates on rising edge.
- i_ctrl_rst_n  in  1  reset; asynchronous, active-low.
- i_sram_cs  in  1  chip select, active-low; high asynchronously returns protocol FSM to CMD0.
- i_sram_data  in  4  nibble from controller.
- o_sram_data  out  4  read nibble to controller.
- o_sram_oe  out  1  high while responder drives data (controller in input mode).

## Operation

- Transaction: CS low, then nibbles MSB-first: command (2), address (4, 16-bit), then read: dummy (2) followed by data; write: data immediately. Data bytes are 2 nibbles, high nibble first.
- Commands: 0x03 = READ, 0x02 = WRITE; any other value = unsupported.
- FSM states: CMD0, CMD1, ADDR, DUMMY, RDATA, WDATA, IGNORE. A 2-bit nibble counter sequences ADDR (0..3), DUMMY (0..1) and data nibble phase (0..1).
  - CMD0: capture high command nibble -> CMD1.
  - CMD1: complete command; 0x02/0x03 -> ADDR; otherwise -> IGNORE.
  - ADDR: shift in nibble; after 4th -> DUMMY (READ) or WDATA (WRITE).
  - DUMMY: input ignored; after 2nd -> RDATA.
  - RDATA/WDATA/IGNORE: remain until CS high.
- Address: only low ADDR_W bits of the 16-bit address are kept; upper bits ignored (aliasing). Address register is ADDR_W wide; increments after each complete byte, wrapping 2^ADDR_W-1 -> 0.
- Write: phase 0 latches high nibble in holding register; phase 1 writes mem[addr] = {hold, nibble}, addr++. Partial byte at CS rise is discarded.
- Read: data nibble registered; mem[addr][7:4] then mem[addr][3:0], addr++ after low nibble, continuing indefinitely.
- CS high or reset: FSM -> CMD0, counter 0, o_sram_oe 0. Memory array is never reset; contents survive reset and CS.
- IGNORE: no array write, o_sram_oe 0.

## Timing

- Reset values: o_sram_oe 0, o_sram_data 0, FSM CMD0, counter 0, address 0.
- o_sram_oe = (FSM in RDATA) & ~i_sram_cs; drops combinationally on CS rise.
- Read latency: on the rising edge sampling the 2nd dummy nibble, o_sram_data <= mem[addr][7:4] and FSM -> RDATA; controller samples it on the next edge, at which o_sram_data <= low nibble; next edge presents the following byte's high nibble. One nibble per SCK, no gaps.
- Write: array update occurs on the edge sampling the low nibble; a read of that address in a later transaction returns the new value.
- CS rising mid-nibble-sequence: no state survives to the next transaction except array contents.
- Reset asserted mid-transaction: same as CS rise; a write whose low nibble was not yet sampled does not occur.
- First edge after CS falls is always treated as command nibble 0.

## Test plan

- WRITE 0x0010 data 0xA5,0x3C; new transaction READ 0x0010 -> o_sram_data 0xA,0x5,0x3,0xC on consecutive edges after dummy, o_sram_oe 1 only during data.
- ADDR_W=8: WRITE 0x00FF data 0x11,0x22; READ 0x0000 -> 0x22; READ 0x00FF -> 0x11 then 0x22 (wrap).
- WRITE 0x1210 data 0x77; READ 0x0010 -> 0x77 (upper bits ignored).
- Command 0xFF, then address and 8 nibbles -> o_sram_oe stays 0, no array change (READ back prior contents unchanged).
- WRITE 0x0020 data 0x9 (high nibble only) then CS high; READ 0x0020 -> previous value unchanged; next transaction decodes command correctly.
- Reset pulsed mid-READ data phase -> o_sram_oe 0 immediately, o_sram_data 0; subsequent READ returns array contents intact.
